fetch_pc_gen: RTL and testbench

Fetch-stage PC generator and direction predictor for the 5-stage core. Holds the fetch PC register, selects the next fetch PC from the execute-stage redirect, the stall hold, the BTB-predicted target, or the sequential PC, and owns a bimodal table of 2-bit saturating counters. The direction table is indexed by pcF and qualifies the BTB hit. The block sits directly upstream of the BTB: its pcF drives the BTB read port, and it consumes BTBHit/branchimmF in the same cycle. It carries the taken prediction into Decode so Execute can detect mispredicts.

---
 rtl/fetch_pc_gen_pkg.sv | 21 ++
 rtl/fetch_pc_gen_if.sv | 29 ++
 rtl/fetch_pc_gen_bht_counters.sv | 31 +++
 rtl/fetch_pc_gen.sv | 51 +++++
 tb/tb_fetch_pc_gen.sv | 103 ++++++++++
 5 files changed

// File: rtl/fetch_pc_gen_pkg.sv
// fetch_pc_gen_pkg: shared branch-predictor counter encodings and update helper
package fetch_pc_gen_pkg;

   typedef enum logic [1:0] {
      SNT = 2'b00,
      WNT = 2'b01,
      WT  = 2'b10,
      ST  = 2'b11
   } ctr_t;

   localparam logic [31:0] PC_STEP = 32'd4;

   function automatic ctr_t sat_update(input ctr_t c, input logic taken);
      return taken ? ((c == ST) ? ST : ctr_t'(c + 2'd1)) : ((c == SNT) ? SNT : ctr_t'(c - 2'd1));
   endfunction

   function automatic logic pred_taken(input ctr_t c);
      return c[1];
   endfunction

endpackage

// File: rtl/fetch_pc_gen_if.sv
// fetch_pc_gen_if: fetch-stage control, BTB and branch-resolution signals around the PC generator
interface fetch_pc_gen_if;
   logic        stallF;
   logic        stallD;
   logic        flushD;
   logic        BTBHit;
   logic [31:0] branchimmF;
   logic        redirectE;
   logic [31:0] redirect_pcE;
   logic        bhtWriteE;
   logic [31:0] pcE;
   logic        takenE;
   logic [31:0] pcF;
   logic [31:0] pcplus4F;
   logic        predTakenF;
   logic        predTakenD;

   modport slave (
      input  stallF, stallD, flushD, BTBHit, branchimmF, redirectE, redirect_pcE,
      input  bhtWriteE, pcE, takenE,
      output pcF, pcplus4F, predTakenF, predTakenD
   );

   modport master (
      output stallF, stallD, flushD, BTBHit, branchimmF, redirectE, redirect_pcE,
      output bhtWriteE, pcE, takenE,
      input  pcF, pcplus4F, predTakenF, predTakenD
   );
endinterface

// File: rtl/fetch_pc_gen_bht_counters.sv
// bht_counters: untagged table of 2-bit saturating counters, async read, sync write and reset
module bht_counters
   import fetch_pc_gen_pkg::*;
#(
   parameter int INDEX_SIZE = 10
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [INDEX_SIZE-1:0] rd_idx_i,
   output ctr_t                  rd_ctr_o,
   input  logic                  we_i,
   input  logic [INDEX_SIZE-1:0] wr_idx_i,
   input  logic                  taken_i
);

   localparam int ENTRIES = 2 ** INDEX_SIZE;

   ctr_t ctr_q [ENTRIES];

   assign rd_ctr_o = ctr_q[rd_idx_i];

   // reset every entry to weak not-taken, otherwise train the resolved entry (no read bypass)
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < ENTRIES; i++) ctr_q[i] <= WNT;
      end else if (we_i) begin
         ctr_q[wr_idx_i] <= sat_update(ctr_q[wr_idx_i], taken_i);
      end
   end

endmodule

// File: rtl/fetch_pc_gen.sv
// fetch_pc_gen: fetch PC register, next-PC selection and bimodal direction prediction
module fetch_pc_gen
   import fetch_pc_gen_pkg::*;
#(
   parameter int          INDEX_SIZE = 10,
   parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
   input logic           clk,
   input logic           reset,
   fetch_pc_gen_if.slave bus
);

   logic [31:0] pc_q, pc_d;
   logic        pred_q, pred_d;
   ctr_t        rd_ctr;

   bht_counters #(.INDEX_SIZE(INDEX_SIZE)) u_bht (
      .clk      (clk),
      .reset    (reset),
      .rd_idx_i (pc_q[INDEX_SIZE+1:2]),
      .rd_ctr_o (rd_ctr),
      .we_i     (bus.bhtWriteE),
      .wr_idx_i (bus.pcE[INDEX_SIZE+1:2]),
      .taken_i  (bus.takenE)
   );

   assign bus.pcF        = pc_q;
   assign bus.pcplus4F   = pc_q + PC_STEP;
   assign bus.predTakenF = bus.BTBHit && pred_taken(rd_ctr);
   assign bus.predTakenD = pred_q;

   // next fetch PC: redirect beats stall, stall beats prediction, prediction beats sequential
   always_comb begin
      pc_d = bus.redirectE ? bus.redirect_pcE :
             bus.stallF ? pc_q :
             bus.predTakenF ? pc_q + bus.branchimmF : pc_q + PC_STEP;
      pred_d = bus.flushD ? 1'b0 : bus.stallD ? pred_q : bus.predTakenF;
   end

   // PC and F->D prediction registers
   always_ff @(posedge clk) begin
      if (reset) begin
         pc_q   <= RESET_PC;
         pred_q <= 1'b0;
      end else begin
         pc_q   <= pc_d;
         pred_q <= pred_d;
      end
   end

endmodule

// File: tb/tb_fetch_pc_gen.sv
// tb_fetch_pc_gen: directed checks of next-PC priority, counter training and predTakenD control
module tb_fetch_pc_gen;

   logic clk = 1'b0;
   logic reset;
   int   n_chk = 0;
   int   n_pass = 0;

   fetch_pc_gen_if bus ();

   fetch_pc_gen #(.INDEX_SIZE(10), .RESET_PC(32'h0)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] ctr(input int idx);
      return 32'(dut.u_bht.ctr_q[idx]);
   endfunction

   initial begin
      reset = 1'b1;
      bus.stallF = 0; bus.stallD = 0; bus.flushD = 0; bus.BTBHit = 0;
      bus.branchimmF = 0; bus.redirectE = 1; bus.redirect_pcE = 32'h100;
      bus.bhtWriteE = 0; bus.pcE = 0; bus.takenE = 0;
      tick();
      chk("rst1_pc", bus.pcF, 32'h0);
      chk("rst1_pd", 32'(bus.predTakenD), 32'h0);
      tick();
      chk("rst2_pc", bus.pcF, 32'h0);
      chk("rst2_pd", 32'(bus.predTakenD), 32'h0);
      chk("rst_ctr", ctr(16), 32'h1);
      reset = 0; bus.redirectE = 0;
      #1 chk("rel_pc0", bus.pcF, 32'h0);
      chk("rel_p4", bus.pcplus4F, 32'h4);
      tick(); chk("rel_pc4", bus.pcF, 32'h4);
      tick(); chk("rel_pc8", bus.pcF, 32'h8);
      bus.redirectE = 1; bus.redirect_pcE = 32'h40;
      tick(); chk("redir_40", bus.pcF, 32'h40);
      bus.redirectE = 0; bus.BTBHit = 1; bus.branchimmF = 32'h20;
      #1 chk("btb_nt_pf", 32'(bus.predTakenF), 32'h0);
      tick(); chk("btb_nt_pc", bus.pcF, 32'h44);
      chk("btb_nt_pd", 32'(bus.predTakenD), 32'h0);
      bus.BTBHit = 0; bus.stallF = 1; bus.bhtWriteE = 1; bus.pcE = 32'h40; bus.takenE = 1;
      tick(); chk("train_10", ctr(16), 32'h2);
      chk("stall_hold", bus.pcF, 32'h44);
      tick(); chk("train_11", ctr(16), 32'h3);
      bus.bhtWriteE = 0; bus.redirectE = 1; bus.redirect_pcE = 32'h40;
      tick(); chk("redir_40b", bus.pcF, 32'h40);
      bus.redirectE = 0; bus.stallF = 0; bus.BTBHit = 1;
      #1 chk("tk_pf", 32'(bus.predTakenF), 32'h1);
      tick(); chk("tk_pc", bus.pcF, 32'h60);
      chk("tk_pd", 32'(bus.predTakenD), 32'h1);
      bus.BTBHit = 0; bus.stallF = 1; bus.bhtWriteE = 1; bus.takenE = 1;
      for (int i = 0; i < 3; i++) begin
         tick(); chk("sat_hi", ctr(16), 32'h3);
      end
      bus.takenE = 0;
      for (int i = 0; i < 4; i++) begin
         tick(); chk("dec", ctr(16), (i < 3) ? 32'(2 - i) : 32'h0);
      end
      bus.bhtWriteE = 0; bus.redirectE = 1; bus.redirect_pcE = 32'h200;
      tick(); chk("redir_stall", bus.pcF, 32'h200);
      bus.redirectE = 0;
      tick(); chk("stall_200", bus.pcF, 32'h200);
      bus.redirectE = 1; bus.redirect_pcE = 32'h80;
      tick(); chk("redir_80", bus.pcF, 32'h80);
      bus.redirectE = 0; bus.bhtWriteE = 1; bus.pcE = 32'h80; bus.takenE = 1;
      bus.BTBHit = 1; bus.branchimmF = 32'h10;
      #1 chk("rw_old", 32'(bus.predTakenF), 32'h0);
      tick(); bus.bhtWriteE = 0;
      #1 chk("rw_new", 32'(bus.predTakenF), 32'h1);
      chk("rw_pc", bus.pcF, 32'h80);
      tick(); chk("pd_set", 32'(bus.predTakenD), 32'h1);
      bus.stallD = 1; bus.BTBHit = 0;
      tick(); chk("pd_hold", 32'(bus.predTakenD), 32'h1);
      bus.flushD = 1;
      tick(); chk("pd_flush", 32'(bus.predTakenD), 32'h0);
      bus.flushD = 0; bus.stallD = 0; bus.BTBHit = 1;
      tick(); chk("pd_reload", 32'(bus.predTakenD), 32'h1);
      reset = 1; bus.redirectE = 1; bus.redirect_pcE = 32'h300;
      bus.stallF = 0; bus.bhtWriteE = 1; bus.pcE = 32'h80; bus.takenE = 1;
      tick(); chk("mid_rst_pc", bus.pcF, 32'h0);
      chk("mid_rst_pd", 32'(bus.predTakenD), 32'h0);
      chk("mid_rst_ctr", ctr(32), 32'h1);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
